// File: rtl/apb_master.sv
// apb_master: single-initiator APB bridge for the CPU data-memory port.
// It accepts one load/store at a time and decodes the address to one of
// NUM_SLAVES peripheral windows. It then runs a SETUP->ACCESS APB transfer
// and returns a one-cycle completion pulse with the load data.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN. When it is defined, an
// ACCESS phase that sees no PREADY for TIMEOUT_CYCLES cycles is aborted
// with rsp_err=1.
//
// Ports:
//   PCLK, PRESET            clock, async active-high reset
//   req/req_write/req_addr/req_wdata   CPU request (sampled in IDLE only)
//   rsp_valid/rsp_err/rsp_rdata        completion pulse, error, load data
//   busy                    high whenever the FSM is not IDLE
//   PADDR/PWRITE/PWDATA/PSEL/PENABLE   APB initiator outputs
//   PRDATA/PREADY           per-slave read data (32 bits each) and ready
module apb_master #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       req,
  input  logic                       req_write,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic                       rsp_err,
  output logic [31:0]                rsp_rdata,
  output logic                       busy,
  output logic [31:0]                PADDR,
  output logic                       PWRITE,
  output logic [31:0]                PWDATA,
  output logic [NUM_SLAVES-1:0]      PSEL,
  output logic                       PENABLE,
  input  logic [32*NUM_SLAVES-1:0]   PRDATA,
  input  logic [NUM_SLAVES-1:0]      PREADY
);

  localparam int unsigned DW    = 32;
  localparam int unsigned IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx_q;

  logic [IDX_W-1:0]      req_idx_c;
  logic                  hit_c;
  logic [NUM_SLAVES-1:0] req_sel_c;
  logic                  ready_c;
  logic [DW-1:0]         rdata_c;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 5) ? $clog2(TIMEOUT_CYCLES + 1) : 5;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  // Address decode: region match on [31:16], window index on [15:12].
  assign req_idx_c = req_addr[15:12];
  assign hit_c     = (req_addr[31:16] == BASE_ADDR[31:16]) &&
                     ({1'b0, req_idx_c} < 5'(NUM_SLAVES));

  // One-hot select for the request, and ready/rdata mux of the latched slave.
  // Loops keep every index in range for any NUM_SLAVES.
  always_comb begin
    req_sel_c = '0;
    ready_c   = 1'b0;
    rdata_c   = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_sel_c[i] = (req_idx_c == IDX_W'(i));
      if (idx_q == IDX_W'(i)) begin
        ready_c = PREADY[i];
        rdata_c = PRDATA[i*DW +: DW];
      end
    end
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_c) begin
              PADDR  <= req_addr;
              PWRITE <= req_write;
              PWDATA <= req_wdata;
              PSEL   <= req_sel_c;
              idx_q  <= req_idx_c;
              busy   <= 1'b1;
              state  <= SETUP;
            end else begin
              // Decode miss: complete with error and stay ready for the next request.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
        end

        ACCESS: begin
          // Ready wins over a timeout that expires on the same edge.
          if (ready_c) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? '0 : rdata_c;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end

        default: begin
          PSEL    <= '0;
          PENABLE <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: self-checking bench for apb_master (NUM_SLAVES=4).
// Completions are scored against a queue of expected {err, rdata} entries.
// Those entries are pushed when each request is driven. The bench also
// makes direct cycle-by-cycle checks of the APB signals.
module tb_apb_master;

  localparam int unsigned NS = 4;

  logic            PCLK;
  logic            PRESET;
  logic            req;
  logic            req_write;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;
  logic            rsp_valid;
  logic            rsp_err;
  logic [31:0]     rsp_rdata;
  logic            busy;
  logic [31:0]     PADDR;
  logic            PWRITE;
  logic [31:0]     PWDATA;
  logic [NS-1:0]   PSEL;
  logic            PENABLE;
  logic [32*NS-1:0] PRDATA;
  logic [NS-1:0]   PREADY;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int n_exp    = 0;
  logic [32:0] exp_q[$];

  apb_master #(
    .NUM_SLAVES    (NS),
    .BASE_ADDR     (32'h1000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req      (req),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the middle of the next cycle.
  task automatic tick();
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic expect_rsp(input logic err, input logic [31:0] data);
    exp_q.push_back({err, data});
    n_exp++;
  endtask

  // Drive a request for one cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req       = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req = 1'b0;
  endtask

  // Scoreboard: every completion pulse must match the oldest expectation.
  always @(negedge PCLK) begin
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_err", 32'(rsp_err), 32'(e[32]));
        check("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET    = 1'b1;
    req       = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = '0;
    // Distinct per-slave read data: slave3..slave0.
    PRDATA    = {32'h0000_005A, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_0011};
    tick();
    tick();
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_paddr", PADDR, 32'd0);
    PRESET = 1'b0;
    tick();

    // Zero-wait store to slave 1.
    expect_rsp(1'b0, 32'd0);
    issue(1'b1, 32'h1000_1000, 32'h41);
    check("st_psel_c1", 32'(PSEL), 32'h2);
    check("st_penable_c1", 32'(PENABLE), 32'd0);
    check("st_busy_c1", 32'(busy), 32'd1);
    check("st_paddr_c1", PADDR, 32'h1000_1000);
    check("st_pwrite_c1", 32'(PWRITE), 32'd1);
    check("st_pwdata_c1", PWDATA, 32'h41);
    tick();
    check("st_psel_c2", 32'(PSEL), 32'h2);
    check("st_penable_c2", 32'(PENABLE), 32'd1);
    PREADY = 4'b0010;
    tick();
    PREADY = '0;
    check("st_rv_c3", 32'(rsp_valid), 32'd1);
    check("st_psel_c3", 32'(PSEL), 32'd0);
    check("st_penable_c3", 32'(PENABLE), 32'd0);
    check("st_busy_c3", 32'(busy), 32'd0);
    tick();

    // Wait-state load from slave 3: ready in cycle 5, completion in cycle 6.
    expect_rsp(1'b0, 32'h5A);
    issue(1'b0, 32'h1000_300C, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      check("ld_paddr_hold", PADDR, 32'h1000_300C);
      check("ld_psel_hold", 32'(PSEL), 32'h8);
      check("ld_rv_wait", 32'(rsp_valid), 32'd0);
      check("ld_penable", 32'(PENABLE), (c == 1) ? 32'd0 : 32'd1);
      if (c == 5) PREADY = 4'b1000;
      tick();
    end
    PREADY = '0;
    check("ld_rv_c6", 32'(rsp_valid), 32'd1);
    check("ld_busy_c6", 32'(busy), 32'd0);
    tick();

    // Decode misses (wrong region, window index beyond NUM_SLAVES), back to back,
    // followed at once by a zero-wait load from slave 0.
    expect_rsp(1'b1, 32'd0);
    issue(1'b0, 32'h2000_0000, 32'h0);
    check("miss_rv_c1", 32'(rsp_valid), 32'd1);
    check("miss_err_c1", 32'(rsp_err), 32'd1);
    check("miss_psel_c1", 32'(PSEL), 32'd0);
    check("miss_busy_c1", 32'(busy), 32'd0);
    expect_rsp(1'b1, 32'd0);
    issue(1'b0, 32'h1000_5000, 32'h0);
    check("miss2_rv", 32'(rsp_valid), 32'd1);
    check("miss2_psel", 32'(PSEL), 32'd0);
    expect_rsp(1'b0, 32'h11);
    issue(1'b0, 32'h1000_0004, 32'h0);
    check("b2b_psel_c1", 32'(PSEL), 32'h1);
    tick();
    PREADY = 4'b0001;
    tick();
    PREADY = '0;
    check("b2b_rv_c3", 32'(rsp_valid), 32'd1);
    tick();

    // Slave 0 never ready.
`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int n;
      n = 0;
      expect_rsp(1'b1, 32'd0);
      issue(1'b0, 32'h1000_0000, 32'h0);
      for (int c = 0; c < 40 && PSEL[0]; c++) begin
        n++;
        tick();
      end
      check("tmo_psel_cycles", 32'(n), 32'd17);
      check("tmo_rv", 32'(rsp_valid), 32'd1);
      check("tmo_err", 32'(rsp_err), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      tick();
    end
`else
    begin
      logic bad;
      bad = 1'b0;
      issue(1'b0, 32'h1000_0000, 32'h0);
      repeat (100) begin
        if (busy !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== 4'b0001) bad = 1'b1;
        tick();
      end
      check("hang_no_timeout", 32'(bad), 32'd0);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      tick();
      check("hang_reset_busy", 32'(busy), 32'd0);
    end
`endif

    // Second request during ACCESS ignored; foreign PREADY ignored.
    expect_rsp(1'b0, 32'd0);
    issue(1'b1, 32'h1000_1010, 32'h0000_CAFE);
    tick();
    PREADY    = 4'b0100;
    req       = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h1000_2000;
    tick();
    check("fr_psel", 32'(PSEL), 32'h2);
    check("fr_penable", 32'(PENABLE), 32'd1);
    check("fr_rv", 32'(rsp_valid), 32'd0);
    PREADY = 4'b0010;
    req    = 1'b0;
    tick();
    PREADY = '0;
    check("fr_rv_done", 32'(rsp_valid), 32'd1);
    check("fr_pwdata_hold", PWDATA, 32'h0000_CAFE);
    check("fr_paddr_hold", PADDR, 32'h1000_1010);
    repeat (3) tick();
    check("fr_not_queued", 32'(PSEL), 32'd0);

    // Asynchronous reset in the middle of ACCESS.
    issue(1'b0, 32'h1000_2008, 32'h0);
    tick();
    check("rst_mid_penable_pre", 32'(PENABLE), 32'd1);
    #2;
    PRESET = 1'b1;
    #1;
    check("rst_mid_psel", 32'(PSEL), 32'd0);
    check("rst_mid_penable", 32'(PENABLE), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge PCLK);
    tick();
    PRESET = 1'b0;
    repeat (5) tick();
    check("rst_mid_idle", 32'(busy), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("rsp_count", 32'(n_rsp), 32'(n_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
